uart_tx_param: RTL
==================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter CLK_HZ, default 125_000_000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line rate in bits/s; CLKS_PER_BIT = CLK_HZ/BAUD (integer divide), SHALL be >= 2 (elaboration error otherwise).
REQ-003 Parameter DATA_BITS, default 8, legal 5..8, data bits per frame.
REQ-004 Parameter PARITY, default 0, 0=none, 1=even, 2=odd; other values SHALL be an elaboration error.
REQ-005 Parameter STOP_BITS, default 1, legal 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 16, power of two >= 2, transmit FIFO entries.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 rst_n  input  1  synchronous, active-low reset.
REQ-009 valid  input  1  write strobe for din.
REQ-010 din  input  8  byte to send; bits above DATA_BITS-1 ignored.
REQ-011 rdy  output  1  FIFO not full; write accepted on edge where valid && rdy.
REQ-012 tx  output  1  serial line, idle high, registered.
REQ-013 busy  output  1  high while a frame is on the line or FIFO non-empty.
REQ-014 overflow  output  1  one-cycle pulse when valid && !rdy (byte dropped).
REQ-015 count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY state skipped when PARITY=0.
REQ-017 Frame: start bit 0, DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits of 1; each bit held exactly CLKS_PER_BIT cycles.
REQ-018 Bit-period counter SHALL run only outside IDLE and SHALL reload to CLKS_PER_BIT-1 on every state entry, so the start bit is full length.
REQ-019 IDLE: on edge where FIFO non-empty, pop one entry and drive tx=0 from that edge (START entered).
REQ-020 Latency: byte written at edge N into empty FIFO with FSM in IDLE SHALL drive tx low from edge N+1.
REQ-021 Even parity bit = XOR of the DATA_BITS sent; odd = its inverse.
REQ-022 At end of last stop bit: FIFO non-empty -> pop and enter START on the same edge (no idle gap); else IDLE with tx=1.
REQ-023 Back-to-back frame period SHALL be (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles exactly.
REQ-024 Simultaneous write and pop on one edge SHALL leave count unchanged; write when full SHALL be dropped, count unchanged, overflow=1 next cycle only.
REQ-025 Write into full FIFO on the same edge as a pop SHALL be refused (rdy reflects pre-edge fullness).
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH.
REQ-027 Pop SHALL never occur when FIFO empty.
REQ-028 busy = (state != IDLE) || (count != 0).

Reset
REQ-029 While rst_n=0 at a rising edge: state=IDLE, tx=1, FIFO emptied (count=0, rdy=1), busy=0, overflow=0, counters cleared.
REQ-030 Reset mid-frame SHALL abort the frame: tx=1 from the reset edge; aborted and queued bytes discarded.
REQ-031 First write accepted on the first edge with rst_n=1.

Verification (CLK_HZ=4, BAUD=1 -> CLKS_PER_BIT=4 unless stated)
REQ-032 8N1, write 0xA5 into empty idle block -> tx from edge N+1: 0,1,0,1,0,0,1,0,1,1, each 4 cycles; busy falls after 40 cycles.
REQ-033 8E1 with 0xA5 -> parity bit 0; 8O1 -> parity bit 1; frame 44 cycles.
REQ-034 7N2, write 0xFF -> 0, seven 1s, two stop 1s; din[7] ignored; 40-cycle frame.
REQ-035 Write 3 bytes back-to-back, 8N1 -> three frames contiguous, start bits at cycles 0, 40, 80; no high gap beyond stop bits.
REQ-036 FIFO_DEPTH=4: write 6 bytes while first frame in progress -> rdy low once full, overflow pulses once per dropped write, count saturates at 4, exactly 5 frames sent (1 in flight + 4 queued).
REQ-037 Assert rst_n=0 mid-DATA with 2 bytes queued -> tx=1 next edge, count=0, busy=0, no further frames.

Source files
------------

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param -- parameterised UART transmitter with a transmit FIFO.
//
// Bytes written with valid/din are queued in a FIFO_DEPTH-entry FIFO and sent
// as frames: start bit (0), DATA_BITS data bits LSB first, optional even/odd
// parity bit, STOP_BITS stop bits (1). Every bit lasts CLK_HZ/BAUD cycles.
// Frames leave back to back while the FIFO holds data.
//
// Ports
//   clk       in   single clock, rising edge
//   rst_n     in   synchronous active-low reset; aborts any frame in flight
//   valid     in   write strobe for din
//   din       in   [7:0] byte to send; bits above DATA_BITS-1 ignored
//   rdy       out  FIFO not full; write accepted on edge with valid && rdy
//   tx        out  serial line, idle high, registered
//   busy      out  frame on the line or FIFO non-empty
//   overflow  out  one-cycle pulse after a write was dropped (FIFO full)
//   count     out  [$clog2(FIFO_DEPTH):0] FIFO occupancy
// -----------------------------------------------------------------------------
package uart_tx_param_pkg;
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;
endpackage

module uart_tx_param #(
    parameter int CLK_HZ     = 125_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid,
    input  logic [7:0]                    din,
    output logic                          rdy,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    // The PARITY state label collides with the PARITY parameter, so it is
    // always referenced through the package; the other labels are imported.
    import uart_tx_param_pkg::state_e;
    import uart_tx_param_pkg::IDLE;
    import uart_tx_param_pkg::START;
    import uart_tx_param_pkg::DATA;
    import uart_tx_param_pkg::STOP;

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    // Guarded so an illegal CLKS_PER_BIT reaches the $error below instead of
    // failing first on a zero-width vector.
    localparam int CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    localparam logic [CW-1:0]   BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      DATA_LAST  = 3'(DATA_BITS - 1);
    localparam logic            STOP_LAST  = 1'(STOP_BITS - 1);
    localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(FIFO_DEPTH);
    localparam logic            ODD_PAR    = (PARITY == 2);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_param: CLK_HZ/BAUD must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
    end

    // Narrow frames deliberately drop the upper din bits.
    if (DATA_BITS < 8) begin : g_unused_din
        logic [7-DATA_BITS:0] unused_din_hi;
        assign unused_din_hi = din[7:DATA_BITS];
    end

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [CNTW-1:0]      count_q;
    logic                 overflow_q;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    // Fullness is taken from the registered count, so a write arriving on
    // the same edge as a pop from a full FIFO is still refused.
    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign push  = valid && !full;

    // NOTE: the storage array is not reset; the pointers and count alone say
    // which entries are valid, which keeps the array mappable onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din[DATA_BITS-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // AW-bit pointers wrap modulo FIFO_DEPTH on their own.
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q    <= count_q + CNTW'(push) - CNTW'(pop);
            overflow_q <= valid && full;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;        // cycles left in current bit
    logic [2:0]           bit_q, bit_d;        // data bit index
    logic                 stop_q, stop_d;      // stop bit index
    logic [DATA_BITS-1:0] shreg_q, shreg_d;    // data, LSB is on the line
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 bit_done;
    logic                 load;

    assign bit_done = (cnt_q == '0);

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        load    = 1'b0;
        pop     = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = cnt_q - CW'(1);
        end

        case (state_q)
            IDLE: begin
                load = !empty;
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    cnt_d   = BIT_LAST;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d   = BIT_LAST;
                    shreg_d = shreg_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        stop_d  = 1'b0;
                        state_d = (PARITY != 0) ? uart_tx_param_pkg::PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            uart_tx_param_pkg::PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                    cnt_d   = BIT_LAST;
                    stop_d  = 1'b0;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (stop_q == STOP_LAST) begin
                        // Chain straight into the next start bit when data
                        // is waiting, otherwise rest the line.
                        load    = !empty;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        stop_d = 1'b1;
                        cnt_d  = BIT_LAST;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // load is only ever raised with the FIFO non-empty.
        if (load) begin
            pop     = 1'b1;
            state_d = START;
            cnt_d   = BIT_LAST;
            shreg_d = mem_q[rd_ptr_q];
            par_d   = (^mem_q[rd_ptr_q]) ^ ODD_PAR;
        end

        // tx is registered: its next value follows the state being entered.
        case (state_d)
            START:                     tx_d = 1'b0;
            DATA:                      tx_d = shreg_d[0];
            uart_tx_param_pkg::PARITY: tx_d = par_d;
            default:                   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rdy      = !full;
    assign tx       = tx_q;
    assign busy     = (state_q != IDLE) || !empty;
    assign overflow = overflow_q;
    assign count    = count_q;

endmodule
